// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator datapath.
//   Q8.8 fixed-point constants used by the score-handling blocks, and the
//   state encoding of the argmax sequencer.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int Q_ONE  = 256;
  localparam int Q_MIN  = -32768;
  localparam int Q_MAX  = 32767;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESULT
  } argmax_state_e;

endpackage

// File: rtl/comparator.sv
// Signed Q8.8 magnitude comparator shared by the classifier back end.
//   a, b      : signed two's-complement operands
//   a_greater : a > b (signed, full width)
//   a_equal   : a == b
//   max_val   : larger of a and b (b on a tie)
module comparator #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     a_greater,
  output logic                     a_equal,
  output logic signed [DATA_W-1:0] max_val
);

  always_comb begin
    a_greater = (a > b);
    a_equal   = (a == b);
    max_val   = a_greater ? a : b;
  end

endmodule

// File: rtl/argmax_sequencer.sv
// Argmax over one classifier output vector.
//   Accepts NUM_CLASSES signed Q8.8 scores (class order 0..NUM_CLASSES-1) on
//   a valid/ready stream after a start pulse, tracks the running maximum and
//   its index through the shared comparator, and presents the result on a
//   valid/ready port. NUM_CLASSES must be at least 2.
//   clk, rst_n           : clock (rising edge), async active-low reset
//   start                : begin a new vector (sampled in IDLE only)
//   in_valid/in_ready    : score stream handshake, in_data = score
//   busy                 : high while a vector is in flight or held
//   out_valid/out_ready  : result handshake
//   class_idx, max_score : winning index and its score
module argmax_sequencer #(
  parameter  int DATA_W      = cnn_pkg::DATA_W,
  parameter  int NUM_CLASSES = 10,
  localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         class_idx,
  output logic signed [DATA_W-1:0] max_score
);

  import cnn_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  argmax_state_e state, state_n;

  logic [IDX_W-1:0]         count;
  logic [IDX_W-1:0]         best_idx;
  logic signed [DATA_W-1:0] best;
  logic                     accept;
  logic                     a_greater;
  logic                     a_equal_unused;
  logic signed [DATA_W-1:0] max_val_unused;

  comparator #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .a         (in_data),
    .b         (best),
    .a_greater (a_greater),
    .a_equal   (a_equal_unused),
    .max_val   (max_val_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (count == LAST_IDX)) state_n = RESULT;
      end
      RESULT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // The first beat seeds the running maximum unconditionally; later beats
  // replace it only on a strict win, so ties keep the lowest index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      best     <= '0;
      best_idx <= '0;
    end else begin
      if (state == IDLE && start) begin
        count <= '0;
      end
      if (accept) begin
        count <= (count == LAST_IDX) ? '0 : count + IDX_W'(1);
        if (count == '0 || a_greater) begin
          best     <= in_data;
          best_idx <= count;
        end
      end
    end
  end

  assign class_idx = best_idx;
  assign max_score = best;

  a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && out_valid));

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= LAST_IDX);

endmodule

// File: tb/tb_argmax_sequencer.sv
// Scoreboard bench for argmax_sequencer: one instance with 4 classes and one
// with the default 10 classes, sharing clock and reset.
module tb_argmax_sequencer;

  typedef int vec_t[16];
  typedef struct {
    int idx;
    int score;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a[2];
  logic        valid_a[2];
  logic [15:0] data_a[2];
  logic        ordy_a[2];

  logic        inr4, busy4, ov4, inr10, busy10, ov10;
  logic [1:0]  cidx4;
  logic [3:0]  cidx10;
  logic [15:0] ms4, ms10;

  argmax_sequencer #(.DATA_W(16), .NUM_CLASSES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .in_valid(valid_a[0]),
    .in_data(data_a[0]), .in_ready(inr4), .busy(busy4), .out_valid(ov4),
    .out_ready(ordy_a[0]), .class_idx(cidx4), .max_score(ms4));

  argmax_sequencer #(.DATA_W(16)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .in_valid(valid_a[1]),
    .in_data(data_a[1]), .in_ready(inr10), .busy(busy10), .out_valid(ov10),
    .out_ready(ordy_a[1]), .class_idx(cidx10), .max_score(ms10));

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  int prev_ov[2];
  int lat_idx[2];
  int lat_max[2];

  function automatic int f_inr(input int d);  return d == 0 ? int'(inr4)  : int'(inr10);  endfunction
  function automatic int f_busy(input int d); return d == 0 ? int'(busy4) : int'(busy10); endfunction
  function automatic int f_ov(input int d);   return d == 0 ? int'(ov4)   : int'(ov10);   endfunction
  function automatic int f_idx(input int d);  return d == 0 ? int'(cidx4) : int'(cidx10); endfunction
  function automatic int f_max(input int d);
    return d == 0 ? int'($signed(ms4)) : int'($signed(ms10));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: find the maximum value, then the lowest index holding it.
  function automatic exp_t ref_argmax(input vec_t v, input int n);
    exp_t e;
    int mx = v[0];
    for (int i = 1; i < n; i++) if (v[i] > mx) mx = v[i];
    e.score = mx;
    e.idx = -1;
    for (int i = n - 1; i >= 0; i--) if (v[i] == mx) e.idx = i;
    return e;
  endfunction

  function automatic vec_t mk4(input int a, input int b, input int c, input int e);
    vec_t r;
    foreach (r[i]) r[i] = 0;
    r[0] = a; r[1] = b; r[2] = c; r[3] = e;
    return r;
  endfunction

  task automatic mon_step(input int d);
    exp_t e;
    int ov = f_ov(d);
    int ci = f_idx(d);
    int ms = f_max(d);
    if (!rst_n) begin
      prev_ov[d] = 0;
      return;
    end
    if (ov != 0 && prev_ov[d] == 0) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        chk("unexpected_result", 1, 0);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk("class_idx", ci, e.idx);
        chk("max_score", ms, e.score);
      end
      lat_idx[d] = ci;
      lat_max[d] = ms;
    end else if (ov != 0) begin
      chk("hold_class_idx", ci, lat_idx[d]);
      chk("hold_max_score", ms, lat_max[d]);
    end
    prev_ov[d] = ov;
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  // gap < 0 picks random idle cycles between beats; hold = cycles with
  // out_ready low in RESULT; pulse = pulse start while held; start_hs =
  // raise start during the releasing RESULT cycle and leave it high.
  task automatic run_vec(input int d, input int n, input vec_t v, input int gap,
                         input int hold, input bit pulse, input bit start_hs);
    exp_t e;
    int waitc;
    int g;
    ordy_a[d] = (hold == 0);
    start_a[d] = 1'b1;
    @(posedge clk); #1;
    start_a[d] = 1'b0;
    chk("run_in_ready", f_inr(d), 1);
    chk("run_busy", f_busy(d), 1);
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (i > 0) begin
        valid_a[d] = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      valid_a[d] = 1'b1;
      data_a[d] = 16'(v[i]);
      waitc = 0;
      while (f_inr(d) == 0 && waitc < 20) begin
        @(posedge clk); #1;
        waitc++;
      end
      if (waitc >= 20) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    valid_a[d] = 1'b0;
    e = ref_argmax(v, n);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    chk("latency_out_valid", f_ov(d), 1);
    chk("result_in_ready", f_inr(d), 0);
    for (int h = 0; h < hold; h++) begin
      if (pulse && h == 1) start_a[d] = 1'b1;
      @(posedge clk); #1;
      start_a[d] = 1'b0;
      chk("held_out_valid", f_ov(d), 1);
      chk("held_in_ready", f_inr(d), 0);
      chk("held_busy", f_busy(d), 1);
    end
    ordy_a[d] = 1'b1;
    if (start_hs) start_a[d] = 1'b1;
    @(posedge clk); #1;
    chk("released_out_valid", f_ov(d), 0);
    chk("idle_busy", f_busy(d), 0);
    if (!start_hs) begin
      @(posedge clk); #1;
      chk("no_restart_busy", f_busy(d), 0);
    end
  endtask

  function automatic int rnd_score();
    int sel = int'($urandom_range(0, 3));
    case (sel)
      0: return -256;
      1: return 1792;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  initial begin
    vec_t v;
    for (int d = 0; d < 2; d++) begin
      start_a[d] = 1'b0; valid_a[d] = 1'b0; data_a[d] = '0; ordy_a[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", f_inr(d), 0);
      chk("rst_busy", f_busy(d), 0);
      chk("rst_out_valid", f_ov(d), 0);
      chk("rst_class_idx", f_idx(d), 0);
      chk("rst_max_score", f_max(d), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_vec(0, 4, mk4(256, -512, 1920, 768), 0, 0, 1'b0, 1'b0);
    run_vec(0, 4, mk4(1792, 1792, 1792, 0), 0, 0, 1'b0, 1'b0);
    run_vec(0, 4, mk4(0, 1792, 1792, 1792), 0, 0, 1'b0, 1'b0);
    run_vec(0, 4, mk4(-32768, -256, -512, -32768), 0, 0, 1'b0, 1'b0);
    run_vec(0, 4, mk4(-32768, -32768, -32768, 32767), 0, 0, 1'b0, 1'b0);
    run_vec(0, 4, mk4(300, -5, 900, 899), 2, 5, 1'b1, 1'b0);

    // Reset part-way through a vector.
    ordy_a[0] = 1'b1;
    start_a[0] = 1'b1;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    valid_a[0] = 1'b1; data_a[0] = 16'd700;
    @(posedge clk); #1;
    data_a[0] = 16'd900;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("amid_in_ready", f_inr(0), 0);
    chk("amid_busy", f_busy(0), 0);
    chk("amid_out_valid", f_ov(0), 0);
    chk("amid_class_idx", f_idx(0), 0);
    chk("amid_max_score", f_max(0), 0);
    valid_a[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", f_ov(0), 0);
    run_vec(0, 4, mk4(0, 512, 256, 128), 0, 0, 1'b0, 1'b0);

    // Ten classes, back to back; start during the result handshake is ignored.
    for (int k = 0; k < 16; k++) v[k] = (k < 10) ? k * 256 : 0;
    run_vec(1, 10, v, 0, 0, 1'b0, 1'b1);
    chk("hs_start_ignored", f_busy(1), 0);
    for (int k = 0; k < 10; k++) v[k] = (9 - k) * 256;
    run_vec(1, 10, v, 0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      foreach (v[k]) v[k] = rnd_score();
      run_vec(0, 4, v, -1, int'($urandom_range(0, 3)), 1'b0, 1'b0);
      foreach (v[k]) v[k] = rnd_score();
      run_vec(1, 10, v, -1, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    repeat (2) @(posedge clk);
    chk("queue_drained", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
